async_fifo_core: RTL and testbench



---
 rtl/async_fifo_pkg.sv | 10 +
 rtl/fifo_ram.sv | 35 +++
 rtl/async_fifo_core.sv | 80 ++++++++
 tb/tb_async_fifo_core.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared constants for the FIFO core.
//   DEF_DATA_W / DEF_ADDR_W : default word width and address width
//   DEPTH                   : number of storage words at the default address width
//   PTR_W                   : pointer width (address bits plus one wrap bit)
package async_fifo_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;
  localparam int PTR_W      = DEF_ADDR_W + 1;
endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array with a synchronous write port and a
// registered read port. Only the read register is cleared by rst. The
// array contents survive reset.
//   clk   : clock
//   rst   : synchronous active-high clear of the read register
//   we    : write enable
//   waddr : write address
//   wdata : write word
//   re    : read enable (loads rdata)
//   raddr : read address
//   rdata : registered read word, holds while re is low
module fifo_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/async_fifo_core.sv
// Single-clock 32-bit FIFO with full/empty flags and registered read data.
// Wrap-bit pointers: equal pointers mean empty; equal addresses with
// differing wrap bits mean full.
// Optional feature macro: ASYNC_FIFO_COUNT_EN adds the fill_level output.
//   w_clk      : clock
//   m_rst      : master reset (sync, active-high)
//   w_rst      : write-side reset (sync, active-high)
//   r_rst      : read-side reset (sync, active-high)
//   w_en       : write request, accepted when not full
//   r_en       : read request, accepted when not empty
//   w_data     : write word
//   w_full     : FIFO holds 2**ADDR_W words
//   r_empty    : FIFO holds no words
//   r_data     : registered read word
//   fill_level : (ASYNC_FIFO_COUNT_EN only) occupancy, 0..2**ADDR_W
module async_fifo_core
  import async_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              w_clk,
  input  logic              m_rst,
  input  logic              w_rst,
  input  logic              r_rst,
  input  logic              w_en,
  input  logic              r_en,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_full,
  output logic              r_empty,
`ifdef ASYNC_FIFO_COUNT_EN
  output logic [ADDR_W:0]   fill_level,
`endif
  output logic [DATA_W-1:0] r_data
);
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic            rst;
  logic [ADDR_W:0] wptr, rptr;
  logic            wr_acc, rd_acc;

  assign rst = m_rst | w_rst | r_rst;

  assign r_empty = (wptr == rptr);
  assign w_full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

  // Each side is judged on its own flag as sampled this cycle. At full the
  // read goes through and the write drops. At empty the write goes through
  // and the read drops, so there is no fall-through.
  assign wr_acc = w_en & ~w_full;
  assign rd_acc = r_en & ~r_empty;

  always_ff @(posedge w_clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + PTR_ONE;
      if (rd_acc) rptr <= rptr + PTR_ONE;
    end
  end

`ifdef ASYNC_FIFO_COUNT_EN
  // Modulo subtraction stays correct across pointer wrap.
  assign fill_level = wptr - rptr;
`endif

  // Reset blocks the array write so a request on the reset edge leaves no trace.
  fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (w_clk),
    .rst   (rst),
    .we    (wr_acc & ~rst),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (w_data),
    .re    (rd_acc & ~rst),
    .raddr (rptr[ADDR_W-1:0]),
    .rdata (r_data)
  );
endmodule

// File: tb/tb_async_fifo_core.sv
module tb_async_fifo_core;
  import async_fifo_pkg::*;

  logic        w_clk;
  logic        m_rst, w_rst, r_rst;
  logic        w_en, r_en;
  logic [31:0] w_data;
  logic        w_full, r_empty;
  logic [31:0] r_data;
`ifdef ASYNC_FIFO_COUNT_EN
  logic [4:0]  fill_level;
`endif

  int checks = 0;
  int errors = 0;

  async_fifo_core dut (
    .w_clk   (w_clk),
    .m_rst   (m_rst),
    .w_rst   (w_rst),
    .r_rst   (r_rst),
    .w_en    (w_en),
    .r_en    (r_en),
    .w_data  (w_data),
    .w_full  (w_full),
    .r_empty (r_empty),
`ifdef ASYNC_FIFO_COUNT_EN
    .fill_level (fill_level),
`endif
    .r_data  (r_data)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic flags(input string tag, input logic e, input logic f);
    chk1({tag, "_empty"}, r_empty, e);
    chk1({tag, "_full"}, w_full, f);
  endtask

  initial begin
    m_rst = 1'b1; w_rst = 1'b0; r_rst = 1'b0;
    w_en = 1'b0; r_en = 1'b0; w_data = '0;

    // Reset
    for (int i = 0; i < 10; i++) step();
    flags("reset", 1'b1, 1'b0);
    chk32("reset_rdata", r_data, 32'h0);
`ifdef ASYNC_FIFO_COUNT_EN
    chk32("reset_level", 32'(fill_level), 32'd0);
`endif
    m_rst = 1'b0;

    // Fill past depth: full from the 16th write on, words 17..20 dropped
    w_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      w_data = i;
      step();
      flags($sformatf("fill%0d", i), 1'b0, i >= DEPTH);
    end
`ifdef ASYNC_FIFO_COUNT_EN
    chk32("fill_level16", 32'(fill_level), 32'd16);
`endif
    w_en = 1'b0;

    // Drain: 1..16 in order, then r_data holds 16
    r_en = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      step();
      chk32($sformatf("drain%0d_data", j), r_data, (j <= 16) ? j : 16);
      flags($sformatf("drain%0d", j), j >= 16, 1'b0);
    end
    r_en = 1'b0;

    // Simultaneous at full
    w_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      w_data = 100 + i;
      step();
    end
    flags("refill", 1'b0, 1'b1);
    w_data = 32'hDEAD; r_en = 1'b1;
    step();
    chk32("full_rw_data", r_data, 32'd101);
    flags("full_rw", 1'b0, 1'b0);
`ifdef ASYNC_FIFO_COUNT_EN
    chk32("full_rw_level", 32'(fill_level), 32'd15);
`endif
    w_en = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      step();
      chk32($sformatf("full_drain%0d", i), r_data, 100 + i);
    end
    flags("full_drained", 1'b1, 1'b0);
    r_en = 1'b0;

    // Simultaneous at empty: write taken, read dropped
    w_en = 1'b1; r_en = 1'b1; w_data = 32'h55;
    step();
    chk32("empty_rw_data", r_data, 32'd116);
    flags("empty_rw", 1'b0, 1'b0);
    w_en = 1'b0;
    step();
    chk32("empty_rw_read", r_data, 32'h55);
    flags("empty_rw_read", 1'b1, 1'b0);
    r_en = 1'b0;

    // Simultaneous at half
    w_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w_data = 200 + i;
      step();
    end
    r_en = 1'b1; w_data = 32'h300;
    step();
    chk32("half_rw_data", r_data, 32'd200);
    flags("half_rw", 1'b0, 1'b0);
`ifdef ASYNC_FIFO_COUNT_EN
    chk32("half_rw_level", 32'(fill_level), 32'd8);
`endif
    w_en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk32($sformatf("half_drain%0d", i), r_data, (i < 8) ? 200 + i : 32'h300);
    end
    flags("half_drained", 1'b1, 1'b0);
    r_en = 1'b0;

    // Wrap-around: 40 write/read pairs carry the pointers through wrap
    for (int k = 0; k < 40; k++) begin
      w_en = 1'b1; w_data = 32'h1000 + k;
      step();
      flags($sformatf("wrap%0d_w", k), 1'b0, 1'b0);
      w_en = 1'b0; r_en = 1'b1;
      step();
      chk32($sformatf("wrap%0d_data", k), r_data, 32'h1000 + k);
      flags($sformatf("wrap%0d_r", k), 1'b1, 1'b0);
      r_en = 1'b0;
    end

    // Mid-stream r_rst with 5 words stored; reset also blocks a same-cycle write
    w_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w_data = 32'h500 + i;
      step();
    end
    flags("mid_pre", 1'b0, 1'b0);
    r_rst = 1'b1; w_data = 32'hBAD;
    step();
    r_rst = 1'b0; w_en = 1'b0;
    flags("mid_rst", 1'b1, 1'b0);
    chk32("mid_rst_data", r_data, 32'h0);
    w_en = 1'b1; w_data = 32'hABC;
    step();
    w_en = 1'b0; r_en = 1'b1;
    step();
    r_en = 1'b0;
    chk32("mid_new_data", r_data, 32'hABC);
    flags("mid_new", 1'b1, 1'b0);

    // w_rst alone also resets
    w_en = 1'b1; w_data = 32'h77;
    step(); step();
    w_en = 1'b0; w_rst = 1'b1;
    step();
    w_rst = 1'b0;
    flags("wrst", 1'b1, 1'b0);
    chk32("wrst_data", r_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
